// File: rtl/tern_to_bin_dec_if.sv
// ----------------------------------------------------------------------------
// tern_to_bin_dec_if
// Handshake bundle for the ternary-to-binary decoder.
//
// Signals:
//   in_valid  : producer has a ternary word on in_trits
//   in_ready  : decoder can accept a word
//   in_trits  : NTRITS trits, 2 bits each, trit 0 in bits [1:0]
//   out_valid : decoded result is available
//   out_ready : consumer takes the result
//   out_bin   : decoded binary value (mod 2^BW)
//   out_err   : word contained at least one illegal trit code (2'b11)
//
// Modports:
//   master : the side that feeds words in and drains results (testbench/system)
//   slave  : the decoder itself
// ----------------------------------------------------------------------------
interface tern_to_bin_dec_if #(
    parameter int NTRITS = 5,
    parameter int BW     = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [2*NTRITS-1:0]   in_trits;
    logic                  out_valid;
    logic                  out_ready;
    logic [BW-1:0]         out_bin;
    logic                  out_err;

    modport master (
        output in_valid,
        output in_trits,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bin,
        input  out_err
    );

    modport slave (
        input  in_valid,
        input  in_trits,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bin,
        output out_err
    );
endinterface

// File: rtl/tern_to_bin_dec.sv
// ----------------------------------------------------------------------------
// tern_to_bin_dec
// Iterative ternary-to-binary decoder. A word of NTRITS trits (2-bit code:
// 00=0, 01=1, 10=2, 11=illegal) is evaluated with Horner's rule, most
// significant trit first, one trit per clock. Illegal trits contribute 0 and
// raise a sticky error flag reported alongside the result.
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous reset, active-low
//   bus   : tern_to_bin_dec_if.slave (input/output valid-ready handshakes,
//           in_trits, out_bin, out_err)
//
// Build option:
//   TERN_DEC_B2B_EN : when defined, a new word may be accepted in the same
//                     cycle the previous result is handed off, so results
//                     come every NTRITS+1 cycles instead of NTRITS+2.
// ----------------------------------------------------------------------------
module tern_to_bin_dec #(
    parameter int NTRITS = 5,
    parameter int BW     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    tern_to_bin_dec_if.slave bus
);

    localparam int IW = (NTRITS > 1) ? $clog2(NTRITS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [2*NTRITS-1:0]   r_trits;
    logic [BW-1:0]         r_acc;
    logic [IW-1:0]         r_idx;
    logic                  r_err;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_out_hs;
    logic [1:0]            w_trit;
    logic                  w_illegal;
    logic [BW-1:0]         w_acc_next;

    // Pick the trit currently addressed by r_idx and form the next Horner
    // step. acc*3 is built as (acc<<1)+acc and everything wraps mod 2^BW.
    always_comb begin
        w_trit = 2'b00;
        for (int i = 0; i < NTRITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_trit = r_trits[2*i +: 2];
            end
        end
        w_illegal  = (w_trit == 2'b11);
        w_acc_next = (r_acc << 1) + r_acc + (w_illegal ? '0 : BW'(w_trit));
    end

    // Handshake outputs. Both are forced low while reset is asserted so the
    // reset cycle never looks like an accept or a result.
    always_comb begin
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        if (rst_n) begin
            case (r_state)
                IDLE: w_in_ready = 1'b1;
                DONE: begin
                    w_out_valid = 1'b1;
`ifdef TERN_DEC_B2B_EN
                    w_in_ready  = bus.out_ready;
`else
                    w_in_ready  = 1'b0;
`endif
                end
                default: begin
                    w_in_ready  = 1'b0;
                    w_out_valid = 1'b0;
                end
            endcase
        end
    end

    assign w_accept = bus.in_valid && w_in_ready;
    assign w_out_hs = w_out_valid && bus.out_ready;

    // Next-state logic. A DONE handshake that coincides with an accept (only
    // possible in back-to-back builds) goes straight into the next conversion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = CONV;
                end
            end
            CONV: begin
                if (r_idx == '0) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (w_out_hs) begin
                    w_next = w_accept ? CONV : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State and datapath registers. Capturing the word reinitialises the
    // accumulator, index and error flag; each CONV cycle consumes one trit
    // from the most significant end downwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_trits <= '0;
            r_acc   <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_trits <= bus.in_trits;
                r_acc   <= '0;
                r_idx   <= IW'(NTRITS - 1);
                r_err   <= 1'b0;
            end else if (r_state == CONV) begin
                r_acc <= w_acc_next;
                r_err <= r_err | w_illegal;
                if (r_idx != '0) begin
                    r_idx <= r_idx - IW'(1);
                end
            end
        end
    end

    // Result is only presented while valid, so out_bin/out_err read zero
    // outside DONE and during reset.
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_bin   = w_out_valid ? r_acc : '0;
    assign bus.out_err   = w_out_valid && r_err;

endmodule

// File: tb/tb_tern_to_bin_dec.sv
// ----------------------------------------------------------------------------
// tb_tern_to_bin_dec
// Self-checking bench for tern_to_bin_dec (NTRITS=5, BW=8). A table of
// directed words with hand-computed results is pushed through one at a time,
// followed by hand-written sequences for reset, backpressure, reset during a
// conversion and back-to-back operation. Honours TERN_DEC_B2B_EN.
// ----------------------------------------------------------------------------
module tb_tern_to_bin_dec;

    localparam int NTRITS = 5;
    localparam int BW     = 8;

    typedef struct {
        logic [2*NTRITS-1:0] trits;
        logic [BW-1:0]       expBin;
        logic                expErr;
    } vec_t;

    logic clk;
    logic rst_n;
    int   nChecks;
    int   nFail;
    int   cyc;

    tern_to_bin_dec_if #(.NTRITS(NTRITS), .BW(BW)) bus ();

    tern_to_bin_dec #(.NTRITS(NTRITS), .BW(BW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to measure result spacing.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Compare one observed value against its expected value and log failures.
    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual != expected) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Push one word through with out_ready held high and check latency,
    // result, error flag and the return of in_ready.
    task automatic applyStimulus(input string tag, input logic [2*NTRITS-1:0] trits,
                                 input int expBin, input int expErr);
        int guard;
        int lat;
        guard = 0;
        while (!bus.in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        checkOutput({tag, "_ready"}, int'(bus.in_ready), 1);
        bus.in_valid = 1'b1;
        bus.in_trits = trits;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_trits = 10'h3FF;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, NTRITS);
        checkOutput({tag, "_bin"}, int'(bus.out_bin), expBin);
        checkOutput({tag, "_err"}, int'(bus.out_err), expErr);
        @(posedge clk); #1;
        checkOutput({tag, "_inready_after"}, int'(bus.in_ready), 1);
    endtask

    vec_t vecs[9];

    initial begin
        int guard;
        int sawValid;
        int nAcc;
        int nRes;
        int resBin[2];
        int resCyc[2];
        int accNow;

        nChecks = 0;
        nFail   = 0;

        vecs[0] = '{trits: 10'h014, expBin: 8'd12,  expErr: 1'b0};
        vecs[1] = '{trits: 10'h2AA, expBin: 8'd242, expErr: 1'b0};
        vecs[2] = '{trits: 10'h000, expBin: 8'd0,   expErr: 1'b0};
        vecs[3] = '{trits: 10'h00C, expBin: 8'd0,   expErr: 1'b1};
        vecs[4] = '{trits: 10'h001, expBin: 8'd1,   expErr: 1'b0};
        vecs[5] = '{trits: 10'h155, expBin: 8'd121, expErr: 1'b0};
        vecs[6] = '{trits: 10'h200, expBin: 8'd162, expErr: 1'b0};
        vecs[7] = '{trits: 10'h0A5, expBin: 8'd76,  expErr: 1'b0};
        vecs[8] = '{trits: 10'h3FF, expBin: 8'd0,   expErr: 1'b1};

        // Reset held for two cycles with in_valid asserted.
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_trits  = 10'h014;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("rst%0d_in_ready", k),  int'(bus.in_ready),  0);
            checkOutput($sformatf("rst%0d_out_valid", k), int'(bus.out_valid), 0);
            checkOutput($sformatf("rst%0d_out_bin", k),   int'(bus.out_bin),   0);
            checkOutput($sformatf("rst%0d_out_err", k),   int'(bus.out_err),   0);
        end
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_rst_in_ready",  int'(bus.in_ready),  1);
        checkOutput("post_rst_out_valid", int'(bus.out_valid), 0);

        // Directed vector table.
        for (int i = 0; i < 9; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].trits,
                          int'(vecs[i].expBin), int'(vecs[i].expErr));
        end

        // Backpressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        bus.in_trits  = 10'h2AA;
        bus.in_valid  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("bp%0d_valid", k),    int'(bus.out_valid), 1);
            checkOutput($sformatf("bp%0d_bin", k),      int'(bus.out_bin),   242);
            checkOutput($sformatf("bp%0d_err", k),      int'(bus.out_err),   0);
            checkOutput($sformatf("bp%0d_in_ready", k), int'(bus.in_ready),  0);
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_release_valid", int'(bus.out_valid), 0);

        // Reset in the middle of a conversion discards the word.
        bus.in_trits = 10'h014;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sawValid = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (bus.out_valid) sawValid = 1;
        end
        checkOutput("midconv_rst_no_valid", sawValid, 0);
        checkOutput("midconv_rst_idle",     int'(bus.in_ready), 1);

        // Back-to-back words with in_valid held and out_ready high.
        bus.out_ready = 1'b1;
        bus.in_trits  = 10'h014;
        bus.in_valid  = 1'b1;
        nAcc = 0;
        nRes = 0;
        resBin[0] = -1; resBin[1] = -1;
        resCyc[0] = 0;  resCyc[1] = 0;
        for (int c = 0; c < 40 && nRes < 2; c++) begin
            accNow = int'(bus.in_valid && bus.in_ready);
            @(posedge clk); #1;
            if (accNow != 0) begin
                nAcc++;
                if (nAcc == 1) bus.in_trits = 10'h2AA;
                else           bus.in_valid = 1'b0;
            end
            if (bus.out_valid) begin
                resBin[nRes] = int'(bus.out_bin);
                resCyc[nRes] = cyc;
                nRes++;
            end
        end
        bus.in_valid = 1'b0;
        checkOutput("b2b_results", nRes, 2);
        checkOutput("b2b_first_bin",  resBin[0], 12);
        checkOutput("b2b_second_bin", resBin[1], 242);
`ifdef TERN_DEC_B2B_EN
        checkOutput("b2b_spacing", resCyc[1] - resCyc[0], NTRITS + 1);
`else
        checkOutput("b2b_spacing", resCyc[1] - resCyc[0], NTRITS + 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/tern_to_bin_dec.md
Name: tern_to_bin_dec

Overview:
Iterative decoder that converts an NTRITS-digit ternary word, in the team's 2-bit trit code (00=0, 01=1, 10=2, 11=illegal), into an unsigned binary value.
- It sits downstream of the ternary carry-lookahead adder chain and turns its sum trits into binary for debug/display logic.
- It uses Horner evaluation, one trit per clock.
- It has a valid/ready handshake on both input and output.

Parameters:
NTRITS, 5, number of trits per input word (>=1).
BW, 8, binary result width; the result is reduced mod 2^BW (BW=8 holds 3^5-1=242 exactly).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous reset, active-low.
in_valid  input  1  input word available.
in_ready  output  1  decoder can accept a word.
in_trits  input  2*NTRITS  trit i at bits [2i+1:2i]; trit 0 is least significant.
out_valid  output  1  result available.
out_ready  input  1  consumer takes result.
out_bin  output  BW  decoded value.
out_err  output  1  at least one illegal code (11) was present in the word.

Behaviour:
- Internal state: trit register, accumulator acc[BW-1:0], index idx, err flag.
- FSM states: IDLE, CONV, DONE.
- Reset (rst_n=0 at a rising edge):
  - State goes to IDLE; acc, idx and err clear.
  - out_valid=0, out_bin=0, out_err=0, in_ready=0 during the reset cycle.
  - Reset mid-CONV or mid-DONE discards the word; no output handshake occurs for it.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: capture in_trits, acc<=0, idx<=NTRITS-1, err<=0, go to CONV.
- CONV:
  - in_ready=0.
  - Each cycle: acc <= acc*3 + val(trit[idx]) mod 2^BW.
  - val(11)=0, and err is set sticky.
  - idx decrements; after the trit at idx=0 is processed, go to DONE.
  - Exactly NTRITS cycles are spent in CONV.
- DONE:
  - out_valid=1; out_bin=acc and out_err=err, held stable until out_ready.
  - On out_valid&out_ready: go to IDLE.
- Latency: the word accepted at edge T gives out_valid=1 in the cycle following edge T+NTRITS.
  - With out_ready held high, in_ready returns 1 in the cycle after the output handshake.
  - Throughput is 1 word per NTRITS+2 cycles.
- in_trits is ignored outside the accept cycle; a change mid-CONV has no effect.
- Arithmetic: acc*3 is computed as (acc<<1)+acc, truncated to BW bits.
  - If BW < ceil(log2(3^NTRITS)), the result is the true value mod 2^BW; no overflow flag.
- out_err=1 does not change the state flow; the word completes normally.

Optional Feature:
Macro TERN_DEC_B2B_EN.
- Defined:
  - In DONE, in_ready=out_ready.
  - A simultaneous output handshake and input handshake captures the new word and goes straight to CONV, with acc/idx/err reinitialised.
  - Throughput becomes 1 word per NTRITS+1 cycles.
  - If out_ready=0, in_ready=0.
- Undefined: in_ready=0 in DONE; behaviour is as described above.

Test Plan:
1. Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> in_ready=0, out_valid=0, out_bin=0, out_err=0; after release, in_ready=1 in IDLE.
2. Basic decode, NTRITS=5: in_trits=10'h014 (trits 00110 = 12), out_ready=1 -> out_valid=1 in the cycle following edge T+5; out_bin=8'd12, out_err=0; in_ready back to 1 the cycle after.
3. Maximum value: in_trits=10'h2AA (22222) -> out_bin=8'd242 (0xF2), out_err=0; all-zero in_trits=10'h000 -> out_bin=0.
4. Illegal code: in_trits=10'h00C (trit1=11, others 0) -> out_bin=0, out_err=1; next word 10'h001 -> out_bin=1, out_err=0 (err not carried over).
5. Backpressure and reset: out_ready=0 for 4 cycles in DONE -> out_valid, out_bin and out_err stable, in_ready=0. Then rst_n=0 for one cycle mid-CONV of a second word -> out_valid never asserts for that word; IDLE afterwards.
6. Back-to-back (TERN_DEC_B2B_EN): out_ready=1 with in_valid held, words 12 then 242 -> second word accepted in the output-handshake cycle of the first; results spaced 6 cycles apart (7 cycles with the macro undefined).
